// File: rtl/fp32_multiplier.sv
// Two-stage IEEE-754 single-precision multiplier: truncating, flush-to-zero,
// with a flag instead of saturation when the result exponent overflows.
module fp32_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] product,
  output logic        overflow
);

  logic [31:0] x_d, x_q;
  logic [31:0] y_d, y_q;
  logic [31:0] product_d, product_q;
  logic        overflow_d, overflow_q;

  logic               sign;
  logic [47:0]        sig_prod;
  logic signed [9:0]  exp_sum;
  logic signed [9:0]  exp_norm;
  logic [22:0]        frac;
  logic               zero_in;

  always_comb begin
    x_d = x;
    y_d = y;
  end

  always_comb begin
    sign     = x_q[31] ^ y_q[31];
    sig_prod = 48'({1'b1, x_q[22:0]}) * 48'({1'b1, y_q[22:0]});
    exp_sum  = $signed({2'b00, x_q[30:23]}) + $signed({2'b00, y_q[30:23]}) - 10'sd127;
    zero_in  = (x_q[30:23] == 8'd0) || (y_q[30:23] == 8'd0);

    // Significand product lies in [1,4); a set top bit means one extra binade.
    if (sig_prod[47]) begin
      frac     = sig_prod[46:24];
      exp_norm = exp_sum + 10'sd1;
    end else begin
      frac     = sig_prod[45:23];
      exp_norm = exp_sum;
    end

    product_d  = {sign, exp_norm[7:0], frac};
    overflow_d = 1'b0;
    if (zero_in) begin
      product_d = 32'h0000_0000;
    end else if (exp_norm >= 10'sd255) begin
      // Exponent field deliberately wraps modulo 256.
      overflow_d = 1'b1;
    end else if (exp_norm <= 10'sd0) begin
      product_d = {sign, 31'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= 32'h0000_0000;
      y_q        <= 32'h0000_0000;
      product_q  <= 32'h0000_0000;
      overflow_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed bench for fp32_multiplier: vector table, latency, and async reset.
module tb_fp32_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] product;
  logic        overflow;

  int n_cmp;
  int n_bad;

  fp32_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  localparam int NV = 15;
  logic [31:0] vx  [NV];
  logic [31:0] vy  [NV];
  logic [31:0] vp  [NV];
  logic        vov [NV];

  initial begin
    vx[0]  = 32'h408a2000; vy[0]  = 32'hc08a2000; vp[0]  = 32'hc1950d08; vov[0]  = 1'b0;
    vx[1]  = 32'hc28aa000; vy[1]  = 32'hc10a2000; vp[1]  = 32'h44159728; vov[1]  = 1'b0;
    vx[2]  = 32'hc28aa000; vy[2]  = 32'h418aa000; vp[2]  = 32'hc49621c8; vov[2]  = 1'b0;
    vx[3]  = 32'h418aa000; vy[3]  = 32'h00000000; vp[3]  = 32'h00000000; vov[3]  = 1'b0;
    vx[4]  = 32'h418aa000; vy[4]  = 32'h3f800000; vp[4]  = 32'h418aa000; vov[4]  = 1'b0;
    vx[5]  = 32'h79807000; vy[5]  = 32'h518aa000; vp[5]  = 32'h0b8b194c; vov[5]  = 1'b1;
    vx[6]  = 32'hb9807000; vy[6]  = 32'h418aa000; vp[6]  = 32'hbb8b194c; vov[6]  = 1'b0;
    // 1.5 * 1.5 = 2.25: normalization carry
    vx[7]  = 32'h3fc00000; vy[7]  = 32'h3fc00000; vp[7]  = 32'h40100000; vov[7]  = 1'b0;
    // 2 * 2 = 4
    vx[8]  = 32'h40000000; vy[8]  = 32'h40000000; vp[8]  = 32'h40800000; vov[8]  = 1'b0;
    // e = 255 exactly: overflow boundary, field wraps to ff
    vx[9]  = 32'h7f000000; vy[9]  = 32'h40000000; vp[9]  = 32'h7f800000; vov[9]  = 1'b1;
    // e = 254: largest in-range exponent
    vx[10] = 32'h7f000000; vy[10] = 32'h3f800000; vp[10] = 32'h7f000000; vov[10] = 1'b0;
    // underflow to signed zero
    vx[11] = 32'h80800000; vy[11] = 32'h00800000; vp[11] = 32'h80000000; vov[11] = 1'b0;
    vx[12] = 32'h00800000; vy[12] = 32'h00800000; vp[12] = 32'h00000000; vov[12] = 1'b0;
    // negative zero operand still gives +0
    vx[13] = 32'h80000000; vy[13] = 32'hc0000000; vp[13] = 32'h00000000; vov[13] = 1'b0;
    // denormal operand is flushed
    vx[14] = 32'h40000000; vy[14] = 32'h00400000; vp[14] = 32'h00000000; vov[14] = 1'b0;
  end

  task automatic apply_and_check(input int i);
    @(negedge clk);
    x = vx[i];
    y = vy[i];
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("vec%0d product", i), product, vp[i]);
    check($sformatf("vec%0d overflow", i), {31'b0, overflow}, {31'b0, vov[i]});
    $display("vec%0d: %08h * %08h -> %08h ov=%0b", i, vx[i], vy[i], product, overflow);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    x = 32'h0;
    y = 32'h0;
    #12;
    check("reset product", product, 32'h0);
    check("reset overflow", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply_and_check(i);

    // Latency: new operands appear after exactly two rising edges.
    apply_and_check(0);
    @(negedge clk);
    x = vx[1];
    y = vy[1];
    @(posedge clk);
    #1;
    check("latency edge1", product, vp[0]);
    @(posedge clk);
    #1;
    check("latency edge2", product, vp[1]);

    // Asynchronous reset between edges, with a nonzero overflowing result held.
    apply_and_check(5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst product", product, 32'h0);
    check("async rst overflow", {31'b0, overflow}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post rst edge1", product, 32'h0);
    @(posedge clk);
    #1;
    check("post rst edge2 product", product, vp[5]);
    check("post rst edge2 overflow", {31'b0, overflow}, {31'b0, vov[5]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
